ccip_rd_line_issuer: RTL

Read-request engine for the AFU side of MPF, driving `af2mpf_sTxPort.c0` and consuming `mpf2af_sRxPort.c0`/`c0TxAlmFull` in the `pClkDiv2` (afu_clk) domain. It accepts a command (start line address, line count) and issues single-line `eREQ_RDLINE_I` reads back-to-back. Outstanding reads are bounded by a credit limit. Returned lines are forwarded in order; MPF is built with `SORT_READ_RESPONSES=1`, so responses arrive in request order. Completion is signalled once every requested line has returned.

---
 rtl/ccip_if_pkg.sv | 69 ++++++
 rtl/rd_issuer_pkg.sv | 31 +++
 rtl/rd_issuer_credit_cnt.sv | 45 ++++
 rtl/ccip_rd_line_issuer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ccip_if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ccip_if_pkg: subset of the CCI-P channel-0 types used by the read issuer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ccip_if_pkg;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

endpackage
`default_nettype wire

// File: rtl/rd_issuer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rd_issuer_pkg: shared state enum, constants and request-header builder.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rd_issuer_pkg;
  import ccip_if_pkg::*;

  localparam int RD_ISSUER_CL_BYTES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } t_rd_issuer_state;

  function automatic t_ccip_c0_ReqMemHdr rd_issuer_hdr(input t_ccip_clAddr addr,
                                                       input t_ccip_mdata  tag);
    t_ccip_c0_ReqMemHdr h;
    h          = '0;
    h.vc_sel   = eVC_VA;
    h.cl_len   = eCL_LEN_1;
    h.req_type = eREQ_RDLINE_I;
    h.address  = addr;
    h.mdata    = tag;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_issuer_credit_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rd_issuer_credit_cnt: in-flight read counter, simultaneous inc/dec,        |
// | decrement ignored at zero, full flag at MAX_OUTSTANDING.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rd_issuer_credit_cnt #(
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inc,
  input  logic                             dec,
  output logic [$clog2(MAX_OUTSTANDING):0] count,
  output logic                             full,
  output logic                             empty
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             dec_ok, inc_ok;

  always_comb begin
    dec_ok  = dec && (count_q != '0);
    inc_ok  = inc && (!full || dec_ok);
    count_d = count_q;
    case ({inc_ok, dec_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ccip_rd_line_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ccip_rd_line_issuer: issues single-line RDLINE_I reads for a command and   |
// | forwards in-order responses. Optional macro RD_ISSUER_PERF_CNT_EN adds     |
// | saturating performance counters.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ccip_rd_line_issuer
  import ccip_if_pkg::*, rd_issuer_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [41:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 c0TxAlmFull,
  input  t_if_ccip_c0_Rx       c0Rx,
  output t_if_ccip_c0_Tx       c0Tx,
  output logic                 rd_valid,
  output logic [511:0]         rd_data,
  output logic [LEN_WIDTH-1:0] rd_idx,
  output logic                 done
`ifdef RD_ISSUER_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_credit_stalls,
  output logic [31:0]          perf_lines
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  t_rd_issuer_state     state_q, state_d;
  t_ccip_clAddr         addr_q, addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] returned_q, returned_d;
  t_if_ccip_c0_Tx       c0Tx_q, c0Tx_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [511:0]         rd_data_q, rd_data_d;
  logic [LEN_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                 done_q, done_d;

  logic                 accept, issue_en, rsp_hit, rsp_ok;
  logic [CNT_W-1:0]     outstanding;
  logic                 credit_full, credit_empty;
  logic                 unused_ok;

  // Responses with nothing in flight are strays (e.g. left over across a reset).
  assign rsp_hit = c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE);
  assign rsp_ok  = rsp_hit && !credit_empty;

  rd_issuer_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .inc   (issue_en),
    .dec   (rsp_hit),
    .count (outstanding),
    .full  (credit_full),
    .empty (credit_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (cmd_len == '0) ? ST_FIN : ST_ISSUE;
      ST_ISSUE: if (issue_en && (issued_d == len_q)) state_d = ST_DRAIN;
      // Looking at returned_d lets done land one cycle after the last rd_valid.
      ST_DRAIN: if (returned_d == len_q) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && !done_q;
    accept    = cmd_valid && cmd_ready;
    issue_en  = (state_q == ST_ISSUE) && (issued_q < len_q) &&
                !credit_full && !c0TxAlmFull;
  end

  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    if (accept) begin
      addr_d     = cmd_addr;
      len_d      = cmd_len;
      issued_d   = '0;
      returned_d = '0;
    end else begin
      if (issue_en) issued_d   = issued_q + 1'b1;
      if (rsp_ok)   returned_d = returned_q + 1'b1;
    end

    c0Tx_d.valid = issue_en;
    c0Tx_d.hdr   = issue_en ? rd_issuer_hdr(addr_q + t_ccip_clAddr'(issued_q),
                                            t_ccip_mdata'(issued_q))
                            : c0Tx_q.hdr;
    rd_valid_d   = rsp_ok;
    rd_data_d    = rsp_ok ? c0Rx.data : rd_data_q;
    rd_idx_d     = rsp_ok ? returned_q : rd_idx_q;
    done_d       = (state_q == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      c0Tx_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      c0Tx_q     <= c0Tx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
      done_q     <= done_d;
    end
  end

  assign c0Tx     = c0Tx_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_idx   = rd_idx_q;
  assign done     = done_q;

  assign unused_ok = ^{c0Rx.hdr.vc_used, c0Rx.hdr.rsvd1, c0Rx.hdr.hit_miss,
                       c0Rx.hdr.rsvd0, c0Rx.hdr.cl_num, c0Rx.hdr.mdata,
                       c0Rx.mmioRdValid, c0Rx.mmioWrValid, outstanding};

`ifdef RD_ISSUER_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_credit_q, perf_credit_d;
  logic [31:0] perf_lines_q, perf_lines_d;
  logic        stall_blk, credit_blk;

  // An almost-full cycle is charged to almFull even when credit is also exhausted.
  always_comb begin
    stall_blk     = (state_q == ST_ISSUE) && (issued_q < len_q) && c0TxAlmFull;
    credit_blk    = (state_q == ST_ISSUE) && (issued_q < len_q) && !c0TxAlmFull &&
                    credit_full;
    perf_stall_d  = perf_stall_q;
    perf_credit_d = perf_credit_q;
    perf_lines_d  = perf_lines_q;
    if (stall_blk  && (perf_stall_q  != '1)) perf_stall_d  = perf_stall_q + 1'b1;
    if (credit_blk && (perf_credit_q != '1)) perf_credit_d = perf_credit_q + 1'b1;
    if (rsp_ok     && (perf_lines_q  != '1)) perf_lines_d  = perf_lines_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q  <= '0;
      perf_credit_q <= '0;
      perf_lines_q  <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_credit_q <= perf_credit_d;
      perf_lines_q  <= perf_lines_d;
    end
  end

  assign perf_stall_cycles  = perf_stall_q;
  assign perf_credit_stalls = perf_credit_q;
  assign perf_lines         = perf_lines_q;
`endif

endmodule
`default_nettype wire
